// File: rtl/alu_issue_if.sv
// Handshake and data bundle between the decode/issue stage, its upstream
// register-read stage and the downstream ALU. The stage itself uses the
// master view; the environment (register read + ALU) uses the slave view.
interface alu_issue_if #(
   parameter int XLEN       = 32,
   parameter int SEL_SIZE   = 5,
   parameter int SHIFT_SIZE = 5
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           instr;
   logic [XLEN-1:0]       rs1_data;
   logic [XLEN-1:0]       rs2_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_SIZE-1:0]   alu_sel;
   logic [XLEN-1:0]       alu_a;
   logic [XLEN-1:0]       alu_b;
   logic [SHIFT_SIZE:0]   shift_amt;
   logic [4:0]            rd_addr;
   logic                  illegal;

   modport master (
      input  flush, in_valid, instr, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, alu_sel, alu_a, alu_b, shift_amt, rd_addr, illegal
   );

   modport slave (
      output flush, in_valid, instr, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, alu_sel, alu_a, alu_b, shift_amt, rd_addr, illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage for RV32I OP / OP-IMM instructions. Decodes the
// instruction into an ALU select code, operands and shift amount, and holds
// the result in a two-entry buffer (output register + skid register) so that
// the stage sustains one instruction per cycle with a registered in_ready.
module alu_issue_stage #(
   parameter int XLEN       = 32,
   parameter int SEL_SIZE   = 5,
   parameter int SHIFT_SIZE = 5
) (
   input logic         clk,
   input logic         rst,
   alu_issue_if.master bus
);

   localparam logic [SEL_SIZE-1:0] SEL_ADD  = SEL_SIZE'(0);
   localparam logic [SEL_SIZE-1:0] SEL_SUB  = SEL_SIZE'(1);
   localparam logic [SEL_SIZE-1:0] SEL_SLT  = SEL_SIZE'(2);
   localparam logic [SEL_SIZE-1:0] SEL_SLTU = SEL_SIZE'(3);
   localparam logic [SEL_SIZE-1:0] SEL_AND  = SEL_SIZE'(4);
   localparam logic [SEL_SIZE-1:0] SEL_OR   = SEL_SIZE'(5);
   localparam logic [SEL_SIZE-1:0] SEL_XOR  = SEL_SIZE'(6);
   localparam logic [SEL_SIZE-1:0] SEL_SLL  = SEL_SIZE'(7);
   localparam logic [SEL_SIZE-1:0] SEL_SRL  = SEL_SIZE'(8);
   localparam logic [SEL_SIZE-1:0] SEL_SRA  = SEL_SIZE'(9);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      logic                illegal;
      logic [SEL_SIZE-1:0] sel;
      logic [XLEN-1:0]     a;
      logic [XLEN-1:0]     b;
      logic [SHIFT_SIZE:0] shamt;
      logic [4:0]          rd;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_t;

   logic [6:0]          opcode;
   logic [2:0]          funct3;
   logic [6:0]          funct7;
   logic [XLEN-1:0]     imm;
   logic                is_op;
   logic                is_imm;
   logic                legal;
   logic                is_shift;
   logic                is_sub;
   logic [SEL_SIZE-1:0] sel;
   entry_t              dec;

   state_t              state_q;
   state_t              state_d;
   logic                in_ready_q;
   logic                accept;
   logic                load_or_in;
   logic                load_or_sk;
   logic                load_sk;
   entry_t              or_q;
   entry_t              sk_q;

   logic                unused_rs1_field;

   assign opcode = bus.instr[6:0];
   assign funct3 = bus.instr[14:12];
   assign funct7 = bus.instr[31:25];
   assign imm    = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
   assign is_op  = (opcode == OPC_OP);
   assign is_imm = (opcode == OPC_OP_IMM);

   // The register specifier rs1 is already resolved into rs1_data upstream.
   assign unused_rs1_field = ^bus.instr[19:15];

   // Decode the presented instruction into the entry that would be captured.
   always_comb begin
      legal    = 1'b1;
      is_shift = 1'b0;
      is_sub   = 1'b0;
      sel      = SEL_ADD;
      dec      = '0;

      case (funct3)
         3'b000: begin
            if (is_op && funct7 == F7_ALT) begin
               sel    = SEL_SUB;
               is_sub = 1'b1;
            end else if (is_imm || funct7 == F7_BASE) begin
               sel = SEL_ADD;
            end else begin
               legal = 1'b0;
            end
         end
         3'b001: begin
            sel      = SEL_SLL;
            is_shift = 1'b1;
            legal    = (funct7 == F7_BASE);
         end
         3'b010: begin
            sel   = SEL_SLT;
            legal = is_imm || funct7 == F7_BASE;
         end
         3'b011: begin
            sel   = SEL_SLTU;
            legal = is_imm || funct7 == F7_BASE;
         end
         3'b100: begin
            sel   = SEL_XOR;
            legal = is_imm || funct7 == F7_BASE;
         end
         3'b101: begin
            is_shift = 1'b1;
            if (funct7 == F7_BASE) begin
               sel = SEL_SRL;
            end else if (funct7 == F7_ALT) begin
               sel = SEL_SRA;
            end else begin
               legal = 1'b0;
            end
         end
         3'b110: begin
            sel   = SEL_OR;
            legal = is_imm || funct7 == F7_BASE;
         end
         default: begin
            sel   = SEL_AND;
            legal = is_imm || funct7 == F7_BASE;
         end
      endcase

      if (!(is_op || is_imm)) begin
         legal = 1'b0;
      end

      if (legal) begin
         dec.sel = sel;
         dec.rd  = bus.instr[11:7];
         // The ALU computes b - a, so SUB presents rs2 as a and rs1 as b.
         if (is_sub) begin
            dec.a = bus.rs2_data;
            dec.b = bus.rs1_data;
         end else begin
            dec.a = bus.rs1_data;
            dec.b = is_op ? bus.rs2_data : imm;
         end
         if (is_shift) begin
            dec.shamt = is_op ? {1'b0, bus.rs2_data[SHIFT_SIZE-1:0]}
                              : {1'b0, bus.instr[19+SHIFT_SIZE:20]};
         end
      end else begin
         dec.illegal = 1'b1;
      end
   end

   assign accept = bus.in_valid && in_ready_q && !bus.flush;

   // Buffer occupancy transitions and which register each edge loads.
   always_comb begin
      state_d    = state_q;
      load_or_in = 1'b0;
      load_or_sk = 1'b0;
      load_sk    = 1'b0;

      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d    = ONE;
                  load_or_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && bus.out_ready) begin
                  load_or_in = 1'b1;
               end else if (accept) begin
                  state_d = FULL;
                  load_sk = 1'b1;
               end else if (bus.out_ready) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (bus.out_ready) begin
                  state_d    = ONE;
                  load_or_sk = 1'b1;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // Occupancy state and the registered in_ready derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
      end
   end

   // Output and skid payload registers; a flush only drops the valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         or_q <= '0;
         sk_q <= '0;
      end else begin
         if (load_or_in) begin
            or_q <= dec;
         end else if (load_or_sk) begin
            or_q <= sk_q;
         end
         if (load_sk) begin
            sk_q <= dec;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.alu_sel   = or_q.sel;
   assign bus.alu_a     = or_q.a;
   assign bus.alu_b     = or_q.b;
   assign bus.shift_amt = or_q.shamt;
   assign bus.rd_addr   = or_q.rd;
   assign bus.illegal   = or_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed vectors with literal expectations
// plus a queue-based reference model checked against the outputs every cycle.
module tb_alu_issue_stage;

   localparam int XLEN       = 32;
   localparam int SEL_SIZE   = 5;
   localparam int SHIFT_SIZE = 5;

   logic clk = 1'b0;
   logic rst;

   alu_issue_if #(.XLEN(XLEN), .SEL_SIZE(SEL_SIZE), .SHIFT_SIZE(SHIFT_SIZE)) bus ();

   alu_issue_stage #(.XLEN(XLEN), .SEL_SIZE(SEL_SIZE), .SHIFT_SIZE(SHIFT_SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] illegal;
      logic [31:0] sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] shamt;
      logic [31:0] rd;
   } exp_t;

   exp_t        model_q[$];
   bit          model_can_take;
   logic [31:0] tbl[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference decode: an RV32I mnemonic table mapped to the ALU contract.
   function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] rs1, input logic [31:0] rs2);
      exp_t        e;
      int          code;
      logic [31:0] imm;
      bit          r;
      bit          im;
      r    = (i[6:0] == 7'h33);
      im   = (i[6:0] == 7'h13);
      imm  = {{20{i[31]}}, i[31:20]};
      code = -1;
      if (r) begin
         case ({i[31:25], i[14:12]})
            10'b0000000_000: code = 0;
            10'b0100000_000: code = 1;
            10'b0000000_010: code = 2;
            10'b0000000_011: code = 3;
            10'b0000000_111: code = 4;
            10'b0000000_110: code = 5;
            10'b0000000_100: code = 6;
            10'b0000000_001: code = 7;
            10'b0000000_101: code = 8;
            10'b0100000_101: code = 9;
            default:         code = -1;
         endcase
      end else if (im) begin
         case (i[14:12])
            3'b000: code = 0;
            3'b010: code = 2;
            3'b011: code = 3;
            3'b111: code = 4;
            3'b110: code = 5;
            3'b100: code = 6;
            3'b001: code = (i[31:25] == 7'b0000000) ? 7 : -1;
            default: code = (i[31:25] == 7'b0000000) ? 8 : (i[31:25] == 7'b0100000) ? 9 : -1;
         endcase
      end
      e.illegal = 0; e.sel = 0; e.a = 0; e.b = 0; e.shamt = 0; e.rd = 0;
      if (code < 0) begin
         e.illegal = 1;
      end else begin
         e.sel = code;
         e.rd  = {27'd0, i[11:7]};
         e.a   = (code == 1) ? rs2 : rs1;
         e.b   = (code == 1) ? rs1 : (r ? rs2 : imm);
         if (code >= 7) begin
            e.shamt = r ? {27'd0, rs2[4:0]} : {27'd0, i[24:20]};
         end
      end
      return e;
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   // Model: a FIFO of at most two decoded entries updated on each rising edge.
   always @(posedge clk) begin
      if (rst || bus.flush) begin
         model_q.delete();
      end else begin
         model_can_take = (model_q.size() < 2);
         if (model_q.size() > 0 && bus.out_ready) begin
            void'(model_q.pop_front());
         end
         if (bus.in_valid && model_can_take) begin
            model_q.push_back(model_decode(bus.instr, bus.rs1_data, bus.rs2_data));
         end
      end
   end

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      checkOutput("m_out_valid", {31'd0, bus.out_valid}, {31'd0, model_q.size() != 0});
      checkOutput("m_in_ready", {31'd0, bus.in_ready}, {31'd0, model_q.size() < 2});
      if (model_q.size() != 0) begin
         checkOutput("m_illegal", {31'd0, bus.illegal}, model_q[0].illegal);
         checkOutput("m_alu_sel", {27'd0, bus.alu_sel}, model_q[0].sel);
         checkOutput("m_alu_a", bus.alu_a, model_q[0].a);
         checkOutput("m_alu_b", bus.alu_b, model_q[0].b);
         checkOutput("m_shift_amt", {26'd0, bus.shift_amt}, model_q[0].shamt);
         checkOutput("m_rd_addr", {27'd0, bus.rd_addr}, model_q[0].rd);
      end
   end

   task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] r1,
                                input logic [31:0] r2, input logic ordy, input logic fl);
      bus.in_valid  = v;
      bus.instr     = i;
      bus.rs1_data  = r1;
      bus.rs2_data  = r2;
      bus.out_ready = ordy;
      bus.flush     = fl;
   endtask

   // Present one instruction and hold it until the stage takes it.
   task automatic pushInstr(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
      bit took;
      took          = 1'b0;
      bus.in_valid  = 1'b1;
      bus.instr     = i;
      bus.rs1_data  = r1;
      bus.rs2_data  = r2;
      for (int k = 0; k < 20 && !took; k++) begin
         took = (bus.in_ready === 1'b1);
         @(negedge clk);
      end
      if (!took) begin
         checks++;
         errors++;
         $display("[TB] FAIL push_timeout: instr 0x%08h not accepted, expected acceptance within 20 cycles", i);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      checkOutput({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      checkOutput({tag, "_alu_sel"}, {27'd0, bus.alu_sel}, 32'd0);
      checkOutput({tag, "_alu_a"}, bus.alu_a, 32'd0);
      checkOutput({tag, "_alu_b"}, bus.alu_b, 32'd0);
      checkOutput({tag, "_shift_amt"}, {26'd0, bus.shift_amt}, 32'd0);
      checkOutput({tag, "_rd_addr"}, {27'd0, bus.rd_addr}, 32'd0);
      checkOutput({tag, "_illegal"}, {31'd0, bus.illegal}, 32'd0);
   endtask

   // Directed scenarios followed by a randomised handshake soak.
   initial begin
      exp_t pin;
      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

      pin = model_decode(32'h402081B3, 32'd10, 32'd3);
      checkOutput("pin_sub_a", pin.a, 32'd3);
      checkOutput("pin_sub_b", pin.b, 32'd10);
      pin = model_decode(32'h40435293, 32'd1, 32'd0);
      checkOutput("pin_srai_sel", pin.sel, 32'd9);
      checkOutput("pin_srai_shamt", pin.shamt, 32'd4);
      pin = model_decode(32'hFFF13093, 32'd0, 32'd0);
      checkOutput("pin_sltiu_b", pin.b, 32'hFFFFFFFF);
      pin = model_decode(32'h00000073, 32'd9, 32'd9);
      checkOutput("pin_ecall_illegal", pin.illegal, 32'd1);

      repeat (2) @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;

      applyStimulus(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("add_out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("add_sel", {27'd0, bus.alu_sel}, 32'd0);
      checkOutput("add_a", bus.alu_a, 32'd5);
      checkOutput("add_b", bus.alu_b, 32'd7);
      checkOutput("add_rd", {27'd0, bus.rd_addr}, 32'd3);
      checkOutput("add_illegal", {31'd0, bus.illegal}, 32'd0);

      applyStimulus(1'b1, 32'h402081B3, 32'd10, 32'd3, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("sub_sel", {27'd0, bus.alu_sel}, 32'd1);
      checkOutput("sub_a", bus.alu_a, 32'd3);
      checkOutput("sub_b", bus.alu_b, 32'd10);

      applyStimulus(1'b1, 32'h40435293, 32'h80000010, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("srai_sel", {27'd0, bus.alu_sel}, 32'd9);
      checkOutput("srai_a", bus.alu_a, 32'h80000010);
      checkOutput("srai_shamt", {26'd0, bus.shift_amt}, 32'd4);
      checkOutput("srai_rd", {27'd0, bus.rd_addr}, 32'd5);

      applyStimulus(1'b1, 32'hFFF13093, 32'd7, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("sltiu_sel", {27'd0, bus.alu_sel}, 32'd3);
      checkOutput("sltiu_b", bus.alu_b, 32'hFFFFFFFF);
      checkOutput("sltiu_rd", {27'd0, bus.rd_addr}, 32'd1);

      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);

      // Backpressure: two entries fill the buffer, the rest wait.
      bus.out_ready = 1'b0;
      pushInstr(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd10), 32'd1, 32'd2);
      pushInstr(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd11), 32'd3, 32'd4);
      applyStimulus(1'b1, enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd12), 32'd5, 32'd6, 1'b0, 1'b0);
      checkOutput("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("bp_stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
         checkOutput("bp_stall_rd", {27'd0, bus.rd_addr}, 32'd10);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("bp_drain_rd1", {27'd0, bus.rd_addr}, 32'd11);
      @(negedge clk);
      checkOutput("bp_drain_rd2", {27'd0, bus.rd_addr}, 32'd12);
      bus.instr = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd13);
      @(negedge clk);
      checkOutput("bp_drain_rd3", {27'd0, bus.rd_addr}, 32'd13);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bp_empty", {31'd0, bus.out_valid}, 32'd0);

      // Flush while full with an input presented.
      bus.out_ready = 1'b0;
      pushInstr(enc_r(7'd0, 5'd2, 5'd1, 3'b110, 5'd20), 32'hA, 32'hB);
      pushInstr(enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd21), 32'hC, 32'hD);
      applyStimulus(1'b1, enc_r(7'd0, 5'd2, 5'd1, 3'b100, 5'd22), 32'hE, 32'hF, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("flush_full_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("flush_full_in_ready", {31'd0, bus.in_ready}, 32'd1);
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);

      // Flush with one entry and an input the stage could otherwise take.
      pushInstr(enc_i(12'h123, 5'd1, 3'b000, 5'd23), 32'd100, 32'd0);
      applyStimulus(1'b1, enc_i(12'h456, 5'd1, 3'b000, 5'd24), 32'd200, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("flush_one_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("flush_one_in_ready", {31'd0, bus.in_ready}, 32'd1);
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);

      // Reset while full.
      bus.out_ready = 1'b0;
      pushInstr(enc_r(7'd0, 5'd2, 5'd1, 3'b001, 5'd25), 32'h1234, 32'h3);
      pushInstr(enc_r(7'd0, 5'd2, 5'd1, 3'b011, 5'd26), 32'h5678, 32'h9);
      applyStimulus(1'b1, enc_r(7'd0, 5'd2, 5'd1, 3'b010, 5'd27), 32'h1, 32'h2, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkResetValues("midrst");
      rst = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);

      // Illegal encodings flow through like legal ones with cleared fields.
      pushInstr(32'h00000073, 32'd55, 32'd66);
      checkOutput("ecall_illegal", {31'd0, bus.illegal}, 32'd1);
      checkOutput("ecall_sel", {27'd0, bus.alu_sel}, 32'd0);
      checkOutput("ecall_a", bus.alu_a, 32'd0);
      checkOutput("ecall_b", bus.alu_b, 32'd0);
      checkOutput("ecall_rd", {27'd0, bus.rd_addr}, 32'd0);
      pushInstr(enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), 32'd55, 32'd66);
      checkOutput("mul_illegal", {31'd0, bus.illegal}, 32'd1);
      checkOutput("mul_a", bus.alu_a, 32'd0);
      checkOutput("mul_rd", {27'd0, bus.rd_addr}, 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("illegal_once", {31'd0, bus.out_valid}, 32'd0);

      // Mixed instructions under random valid/ready/flush.
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b000, 5'd1));
      tbl.push_back(enc_r(7'b0100000,  5'd2, 5'd1, 3'b000, 5'd2));
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b010, 5'd3));
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b011, 5'd4));
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b100, 5'd5));
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b110, 5'd6));
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b111, 5'd7));
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b001, 5'd8));
      tbl.push_back(enc_r(7'd0,        5'd2, 5'd1, 3'b101, 5'd9));
      tbl.push_back(enc_r(7'b0100000,  5'd2, 5'd1, 3'b101, 5'd10));
      tbl.push_back(enc_i(12'h800, 5'd1, 3'b000, 5'd11));
      tbl.push_back(enc_i(12'h7FF, 5'd1, 3'b010, 5'd12));
      tbl.push_back(enc_i(12'hF0F, 5'd1, 3'b110, 5'd13));
      tbl.push_back(enc_i(12'h0F0, 5'd1, 3'b111, 5'd14));
      tbl.push_back(enc_i(12'hFFF, 5'd1, 3'b100, 5'd15));
      tbl.push_back(enc_i(12'h01F, 5'd1, 3'b001, 5'd16));
      tbl.push_back(enc_i(12'h003, 5'd1, 3'b101, 5'd17));
      tbl.push_back(enc_i(12'h41F, 5'd1, 3'b101, 5'd18));
      tbl.push_back(enc_i(12'h41F, 5'd1, 3'b001, 5'd19));
      tbl.push_back(enc_r(7'b0100000,  5'd2, 5'd1, 3'b111, 5'd20));
      tbl.push_back(32'h00A12083);
      for (int n = 0; n < 300; n++) begin
         applyStimulus($urandom_range(0, 3) != 0, tbl[$urandom_range(0, tbl.size() - 1)],
                       $urandom, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("final_empty", {31'd0, bus.out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
